// File: rtl/serial_addsub_if.sv
// Bundle of request/response signals for the bit-serial add/subtract unit.
//   start/sub/a/b/cin : request side, driven by the master
//   busy/done         : progress and one-cycle completion pulse, driven by the slave
//   result/cout/overflow : operation outcome, valid while done=1 and held afterwards
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, result, cout, overflow
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract unit: a single full-adder cell walks the operands
// LSB first, one bit per clock, over WIDTH clocks.
//   clk      : rising-edge clock
//   rst      : asynchronous, active-high reset
//   bus      : serial_addsub_if.slave
//     start  : request, honoured only when not busy
//     sub    : 0 -> a + b + cin, 1 -> a - b - cin (cin is the borrow-in)
//     a, b   : operands
//     busy   : operation in progress
//     done   : one-cycle pulse, result/cout/overflow valid
//     result : sum or difference, held until the next accepted start
//     cout   : raw carry-out (borrow-out = ~cout for subtraction)
//     overflow : signed overflow (carry into MSB xor carry out of MSB)
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  serial_addsub_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // The full-adder cell. Operand registers shift right every bit-cycle, so
  // the bit under evaluation is always at position 0.
  logic sum_bit;
  logic carry_nx;
  assign sum_bit  = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_nx = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          // Subtraction is a + ~b + ~borrow_in, so the same cell serves both.
          state_d  = RUN;
          cnt_d    = '0;
          a_d      = bus.a;
          b_d      = bus.sub ? ~bus.b : bus.b;
          carry_d  = bus.sub ? ~bus.cin : bus.cin;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
        result_d = {sum_bit, result_q[WIDTH-1:1]};
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        carry_d  = carry_nx;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // MSB cell: carry_q is the carry into the MSB, carry_nx the carry out.
          state_d = DONE;
          cnt_d   = '0;
          cout_d  = carry_nx;
          ovf_d   = carry_q ^ carry_nx;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8). A scoreboard of expected
// outcomes, computed with plain integer arithmetic, is checked on every done
// pulse; directed tests add literal expectations and latency checks.
module tb_serial_addsub;

  localparam int W = 8;

  logic clk;
  logic rst;

  serial_addsub_if #(.WIDTH(W)) bus ();

  serial_addsub #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected outcome from arithmetic: unsigned sum for result/cout, exact
  // signed value for overflow.
  function automatic exp_t model(input logic s, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic c);
    exp_t        e;
    int unsigned u;
    int          sx, sy, sv;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!s) begin
      u  = int'(x) + int'(y) + int'(c);
      sv = sx + sy + int'(c);
    end else begin
      u  = int'(x) + ((1 << W) - 1 - int'(y)) + (1 - int'(c));
      sv = sx - sy - int'(c);
    end
    e.res = u[W-1:0];
    e.co  = u[W];
    e.ov  = (sv > (1 << (W - 1)) - 1) || (sv < -(1 << (W - 1)));
    return e;
  endfunction

  // Compare process: every done pulse must match the oldest expectation,
  // and must come after exactly W busy cycles.
  int busy_run = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_run = 0;
    end else begin
      if (bus.busy && bus.done) check("busy_done_overlap", 1, 0);
      if (bus.busy) busy_run++;
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_result", bus.result, e.res);
          check("sb_cout", bus.cout, e.co);
          check("sb_overflow", bus.overflow, e.ov);
          check("sb_busy_cycles", busy_run, W);
        end
        busy_run = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Issue one accepted operation (caller guarantees IDLE or DONE) and wait
  // for its done pulse; operands are scrambled during RUN to show they are
  // ignored.
  task automatic run_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, output logic [W-1:0] r, output logic co,
                        output logic ov);
    int cyc;
    bus.sub = s; bus.a = x; bus.b = y; bus.cin = c; bus.start = 1'b1;
    exp_q.push_back(model(s, x, y, c));
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (cyc == 1) begin
        bus.start = 1'b0;
        bus.a = ~x; bus.b = ~y; bus.sub = ~s; bus.cin = ~c;
      end
    end while (!bus.done && cyc < 30);
    check("latency", cyc, W + 1);
    r  = bus.result;
    co = bus.cout;
    ov = bus.overflow;
  endtask

  logic [W-1:0] vals [16] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd15, 8'd85, 8'd100, 8'd126,
                              8'd127, 8'd128, 8'd129, 8'd170, 8'd200, 8'd240, 8'd254, 8'd255};

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] r;
    logic         co, ov;
    int           cyc;

    rst = 1'b1;
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    tick();
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_cout", bus.cout, 0);
    check("rst_overflow", bus.overflow, 0);
    rst = 1'b0;
    tick();

    // 1: add 200+100
    run_op(1'b0, 8'd200, 8'd100, 1'b0, r, co, ov);
    check("t1_result", r, 44);
    check("t1_cout", co, 1);
    check("t1_overflow", ov, 0);

    // 2: subtraction with and without borrow
    run_op(1'b1, 8'd5, 8'd3, 1'b0, r, co, ov);
    check("t2a_result", r, 2);
    check("t2a_cout", co, 1);
    run_op(1'b1, 8'd3, 8'd5, 1'b0, r, co, ov);
    check("t2b_result", r, 254);
    check("t2b_cout", co, 0);
    check("t2b_overflow", ov, 0);

    // 3: signed overflow both directions
    run_op(1'b0, 8'd127, 8'd1, 1'b0, r, co, ov);
    check("t3a_result", r, 128);
    check("t3a_overflow", ov, 1);
    run_op(1'b1, 8'd128, 8'd1, 1'b0, r, co, ov);
    check("t3b_result", r, 127);
    check("t3b_overflow", ov, 1);

    // 4: second start while busy is ignored
    bus.sub = 1'b0; bus.a = 8'd10; bus.b = 8'd20; bus.cin = 1'b0; bus.start = 1'b1;
    exp_q.push_back(model(1'b0, 8'd10, 8'd20, 1'b0));
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (cyc == 1) bus.start = 1'b0;
      if (cyc == 3) begin bus.start = 1'b1; bus.a = 8'd1; bus.b = 8'd1; end
      if (cyc == 4) bus.start = 1'b0;
    end while (!bus.done && cyc < 30);
    check("t4_latency", cyc, W + 1);
    check("t4_result", bus.result, 30);
    tick();
    check("t4_no_requeue", bus.busy, 0);

    // 5: reset in the middle of an operation
    bus.sub = 1'b0; bus.a = 8'd50; bus.b = 8'd60; bus.cin = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    check("t5_busy_before_rst", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("t5_busy", bus.busy, 0);
    check("t5_done", bus.done, 0);
    check("t5_result", bus.result, 0);
    check("t5_cout", bus.cout, 0);
    check("t5_overflow", bus.overflow, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("t5_idle", bus.busy, 0);
    run_op(1'b0, 8'd7, 8'd9, 1'b1, r, co, ov);
    check("t5_next_result", r, 17);

    // Back-to-back with start held high: one result every W+1 cycles.
    bus.start = 1'b1;
    bus.sub = 1'b0; bus.a = 8'd250; bus.b = 8'd10; bus.cin = 1'b1;
    exp_q.push_back(model(1'b0, 8'd250, 8'd10, 1'b1));
    for (int k = 0; k < 3; k++) begin
      cyc = 0;
      do begin
        tick();
        cyc++;
        if (cyc == 1) begin bus.a = 8'hA5; bus.b = 8'h5A; bus.sub = ~bus.sub; end
      end while (!bus.done && cyc < 30);
      check("b2b_period", cyc, W + 1);
      if (k == 0) begin
        bus.sub = 1'b1; bus.a = 8'd0; bus.b = 8'd1; bus.cin = 1'b0;
        exp_q.push_back(model(1'b1, 8'd0, 8'd1, 1'b0));
      end else if (k == 1) begin
        check("b2b_1_result", bus.result, 255);
        check("b2b_1_cout", bus.cout, 0);
        bus.sub = 1'b0; bus.a = 8'd128; bus.b = 8'd128; bus.cin = 1'b1;
        exp_q.push_back(model(1'b0, 8'd128, 8'd128, 1'b1));
      end else begin
        check("b2b_2_result", bus.result, 1);
        check("b2b_2_overflow", bus.overflow, 1);
        bus.start = 1'b0;
      end
    end
    tick();

    // Sweep over boundary-heavy operand set, both ops, both carry-ins.
    foreach (vals[i]) begin
      foreach (vals[j]) begin
        for (int s = 0; s < 2; s++) begin
          for (int c = 0; c < 2; c++) begin
            run_op(s[0], vals[i], vals[j], c[0], r, co, ov);
          end
        end
      end
    end

    for (int i = 0; i < 3; i++) tick();
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
